// File: rtl/rdcntrl_queues_pkg.sv
// Shared widths, depths, entry layouts and the TMR majority voter for the
// CFEB read-control queueing core.
package rdcntrl_queues_pkg;

    localparam int BLK_W   = 4;
    localparam int L1P_W   = 8;
    localparam int L1AN_W  = 6;
    localparam int T_DEPTH = 3;
    localparam int N_DEPTH = 8;

    typedef struct packed {
        logic              lct_ph;
        logic              dlscafull;
        logic              scnd_blk;
        logic              scnd_sh;
        logic [BLK_W-1:0]  blk;
        logic [L1P_W-1:0]  l1p;
    } trig_entry_t;

    typedef struct packed {
        logic              phase;
        logic [L1AN_W-1:0] l1an;
    } num_entry_t;

    localparam int T_WIDTH = $bits(trig_entry_t);
    localparam int N_WIDTH = $bits(num_entry_t);

    // Bitwise 2-of-3 majority; callers zero-extend into and truncate out of 32 bits.
    function automatic logic [31:0] vote3(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rdcntrl_queues_if.sv
// Push/pop, status and head-entry signals between the trigger/match logic,
// the readout state machine and the queueing core.
interface rdcntrl_queues_if;
    import rdcntrl_queues_pkg::*;

    logic              L1A;
    logic              T_PUSH, T_CEW, T_POP, T_CER;
    logic              LCT_PH_IN, DLSCAFULL, SCND_BLK_IN, SCND_SH_IN;
    logic [BLK_W-1:0]  BLKIN;
    logic [L1P_W-1:0]  L1PIN;
    logic              T_EMPTY, T_FULL;
    logic              LCT_PH_OUT, DGSCAFULL, SCND_BLK_OUT, SCND_SH_OUT;
    logic [BLK_W-1:0]  BLKOUT;
    logic [L1P_W-1:0]  L1POUT, NL1ABLK;
    logic              N_PUSH, N_POP, L1A_PHASE;
    logic [L1AN_W-1:0] L1A_CNT, L1ANUM;
    logic              N_EMPTY, N_FULL, L1A_PHASE_OUT;

    modport master (
        output L1A, T_PUSH, T_CEW, T_POP, T_CER,
               LCT_PH_IN, DLSCAFULL, SCND_BLK_IN, SCND_SH_IN, BLKIN, L1PIN,
               N_PUSH, N_POP, L1A_PHASE,
        input  T_EMPTY, T_FULL, LCT_PH_OUT, DGSCAFULL, SCND_BLK_OUT, SCND_SH_OUT,
               BLKOUT, L1POUT, NL1ABLK, L1A_CNT, N_EMPTY, N_FULL, L1A_PHASE_OUT, L1ANUM
    );

    modport slave (
        input  L1A, T_PUSH, T_CEW, T_POP, T_CER,
               LCT_PH_IN, DLSCAFULL, SCND_BLK_IN, SCND_SH_IN, BLKIN, L1PIN,
               N_PUSH, N_POP, L1A_PHASE,
        output T_EMPTY, T_FULL, LCT_PH_OUT, DGSCAFULL, SCND_BLK_OUT, SCND_SH_OUT,
               BLKOUT, L1POUT, NL1ABLK, L1A_CNT, N_EMPTY, N_FULL, L1A_PHASE_OUT, L1ANUM
    );

endinterface

// File: rtl/rdcntrl_queues_sync_fifo.sv
// First-word-fall-through FIFO with counted occupancy, wrapping pointers, a
// registered head word that holds the last-read value when empty, and optional TMR.
module sync_fifo
    import rdcntrl_queues_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int WIDTH = 16,
    parameter bit TMR   = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             wr_req,
    input  logic             rd_req,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int NC    = TMR ? 3 : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr_q [NC];
    logic [PTR_W-1:0] rd_ptr_q [NC];
    logic [CNT_W-1:0] cnt_q    [NC];
    logic [WIDTH-1:0] dout_q   [NC];
    logic [WIDTH-1:0] mem_q    [NC][DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_inc, rd_ptr_inc;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] dout_n;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr, rd;

    generate
        if (TMR) begin : g_vote
            assign wr_ptr = PTR_W'(vote3(32'(wr_ptr_q[0]), 32'(wr_ptr_q[1]), 32'(wr_ptr_q[2])));
            assign rd_ptr = PTR_W'(vote3(32'(rd_ptr_q[0]), 32'(rd_ptr_q[1]), 32'(rd_ptr_q[2])));
            assign cnt    = CNT_W'(vote3(32'(cnt_q[0]), 32'(cnt_q[1]), 32'(cnt_q[2])));
            assign dout   = WIDTH'(vote3(32'(dout_q[0]), 32'(dout_q[1]), 32'(dout_q[2])));
            for (genvar i = 0; i < DEPTH; i++) begin : g_mem
                assign mem[i] = WIDTH'(vote3(32'(mem_q[0][i]), 32'(mem_q[1][i]), 32'(mem_q[2][i])));
            end
        end else begin : g_plain
            assign wr_ptr = wr_ptr_q[0];
            assign rd_ptr = rd_ptr_q[0];
            assign cnt    = cnt_q[0];
            assign dout   = dout_q[0];
            for (genvar i = 0; i < DEPTH; i++) begin : g_mem
                assign mem[i] = mem_q[0][i];
            end
        end
    endgenerate

    assign empty = (cnt == '0);
    assign full  = (cnt == CNT_W'(DEPTH));
    assign rd    = rd_req & ~empty;
    // A read frees the slot in the same edge, so a full FIFO still takes a paired write.
    assign wr    = wr_req & (~full | rd);

    // NOTE: every always_comb target gets a default first so no latch is inferred.
    always_comb begin
        wr_ptr_inc = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
        rd_ptr_inc = (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
        cnt_n      = cnt;
        if (wr && !rd)      cnt_n = cnt + CNT_W'(1);
        else if (rd && !wr) cnt_n = cnt - CNT_W'(1);
        dout_n     = dout;
        if (wr && (empty || (rd && cnt == CNT_W'(1)))) dout_n = din;
        else if (rd && cnt > CNT_W'(1))                dout_n = mem[rd_ptr_inc];
    end

    // NOTE: state uses non-blocking assignments so every copy samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int c = 0; c < NC; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                cnt_q[c]    <= '0;
                dout_q[c]   <= '0;
            end
        end else begin
            for (int c = 0; c < NC; c++) begin
                if (wr) wr_ptr_q[c] <= wr_ptr_inc;
                if (rd) rd_ptr_q[c] <= rd_ptr_inc;
                cnt_q[c]  <= cnt_n;
                dout_q[c] <= dout_n;
            end
        end
    end

    // NOTE: storage is not reset; the occupancy count and head register gate its use.
    always_ff @(posedge CLK) begin
        for (int c = 0; c < NC; c++) begin
            if (wr) mem_q[c][wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/rdcntrl_queues.sv
// Read-control queueing core: L1A event counter, 3-entry trigger-block FIFO
// and 8-entry L1A-number FIFO between trigger/match logic and readout FSM.
module rdcntrl_queues
    import rdcntrl_queues_pkg::*;
#(
    parameter bit TMR = 1'b0
) (
    input logic             CLK,
    input logic             RST,
    rdcntrl_queues_if.slave bus
);
    localparam int NC = TMR ? 3 : 1;

    logic [L1AN_W-1:0] cnt_q   [NC];
    logic [L1AN_W-1:0] dl1an_q [NC];
    logic [L1AN_W-1:0] l1a_cnt, dl1an;
    trig_entry_t       t_din, t_dout;
    num_entry_t        n_din, n_dout;

    generate
        if (TMR) begin : g_vote
            assign l1a_cnt = L1AN_W'(vote3(32'(cnt_q[0]), 32'(cnt_q[1]), 32'(cnt_q[2])));
            assign dl1an   = L1AN_W'(vote3(32'(dl1an_q[0]), 32'(dl1an_q[1]), 32'(dl1an_q[2])));
        end else begin : g_plain
            assign l1a_cnt = cnt_q[0];
            assign dl1an   = dl1an_q[0];
        end
    endgenerate

    // DL1AN trails the counter by one edge and is what gets queued as the L1A number.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int c = 0; c < NC; c++) begin
                cnt_q[c]   <= '0;
                dl1an_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NC; c++) begin
                cnt_q[c]   <= bus.L1A ? l1a_cnt + L1AN_W'(1) : l1a_cnt;
                dl1an_q[c] <= l1a_cnt;
            end
        end
    end

    assign t_din = {bus.LCT_PH_IN, bus.DLSCAFULL, bus.SCND_BLK_IN, bus.SCND_SH_IN,
                    bus.BLKIN, bus.L1PIN};
    assign n_din = {bus.L1A_PHASE, dl1an};

    sync_fifo #(.DEPTH(T_DEPTH), .WIDTH(T_WIDTH), .TMR(TMR)) u_trig_fifo (
        .CLK    (CLK),
        .RST    (RST),
        .wr_req (bus.T_PUSH & bus.T_CEW),
        .rd_req (bus.T_POP & bus.T_CER),
        .din    (t_din),
        .dout   (t_dout),
        .empty  (bus.T_EMPTY),
        .full   (bus.T_FULL)
    );

    sync_fifo #(.DEPTH(N_DEPTH), .WIDTH(N_WIDTH), .TMR(TMR)) u_num_fifo (
        .CLK    (CLK),
        .RST    (RST),
        .wr_req (bus.N_PUSH),
        .rd_req (bus.N_POP),
        .din    (n_din),
        .dout   (n_dout),
        .empty  (bus.N_EMPTY),
        .full   (bus.N_FULL)
    );

    assign bus.L1A_CNT       = l1a_cnt;
    assign bus.LCT_PH_OUT    = t_dout.lct_ph;
    assign bus.DGSCAFULL     = t_dout.dlscafull;
    assign bus.SCND_BLK_OUT  = t_dout.scnd_blk;
    assign bus.SCND_SH_OUT   = t_dout.scnd_sh;
    assign bus.BLKOUT        = t_dout.blk;
    assign bus.L1POUT        = t_dout.l1p;
    assign bus.NL1ABLK       = ~t_dout.l1p;
    assign bus.L1A_PHASE_OUT = n_dout.phase;
    assign bus.L1ANUM        = n_dout.l1an;

endmodule

// File: tb/tb_rdcntrl_queues.sv
// Scoreboard bench for rdcntrl_queues: directed pushes queue their expected
// head values, a negedge monitor compares them whenever a pop is presented.
module tb_rdcntrl_queues;
    import rdcntrl_queues_pkg::*;

    typedef struct {
        logic [3:0] flg;
        logic [3:0] blk;
        logic [7:0] l1p;
        logic [7:0] nl;
    } t_exp_t;

    typedef struct {
        logic       ph;
        logic [5:0] num;
    } n_exp_t;

    logic   CLK = 1'b0;
    logic   RST = 1'b1;
    int     errors = 0;
    int     checks = 0;
    t_exp_t tq [$];
    n_exp_t nq [$];

    rdcntrl_queues_if bus();

    rdcntrl_queues #(.TMR(1'b0)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic t_cycle(input bit push, input bit cew, input bit pop, input bit cer,
                           input logic [3:0] flg, input logic [3:0] blk,
                           input logic [7:0] l1p, input logic [7:0] nl, input bit accept);
        bus.T_PUSH = push;
        bus.T_CEW  = cew;
        bus.T_POP  = pop;
        bus.T_CER  = cer;
        {bus.LCT_PH_IN, bus.DLSCAFULL, bus.SCND_BLK_IN, bus.SCND_SH_IN} = flg;
        bus.BLKIN  = blk;
        bus.L1PIN  = l1p;
        if (accept) tq.push_back('{flg, blk, l1p, nl});
        tick();
        bus.T_PUSH = 1'b0;
        bus.T_CEW  = 1'b0;
        bus.T_POP  = 1'b0;
        bus.T_CER  = 1'b0;
    endtask

    task automatic n_cycle(input bit push, input bit pop, input bit l1a, input bit ph,
                           input logic [5:0] num, input bit accept);
        bus.N_PUSH    = push;
        bus.N_POP     = pop;
        bus.L1A       = l1a;
        bus.L1A_PHASE = ph;
        if (accept) nq.push_back('{ph, num});
        tick();
        bus.N_PUSH = 1'b0;
        bus.N_POP  = 1'b0;
        bus.L1A    = 1'b0;
    endtask

    always @(negedge CLK) begin
        t_exp_t te;
        n_exp_t ne;
        if (!RST && bus.T_POP && bus.T_CER && !bus.T_EMPTY) begin
            check("t_pop_has_expected", 32'(tq.size() != 0), 1);
            if (tq.size() != 0) begin
                te = tq.pop_front();
                check("t_flags", 32'({bus.LCT_PH_OUT, bus.DGSCAFULL, bus.SCND_BLK_OUT,
                                      bus.SCND_SH_OUT}), 32'(te.flg));
                check("t_blkout", 32'(bus.BLKOUT), 32'(te.blk));
                check("t_l1pout", 32'(bus.L1POUT), 32'(te.l1p));
                check("t_nl1ablk", 32'(bus.NL1ABLK), 32'(te.nl));
            end
        end
        if (!RST && bus.N_POP && !bus.N_EMPTY) begin
            check("n_pop_has_expected", 32'(nq.size() != 0), 1);
            if (nq.size() != 0) begin
                ne = nq.pop_front();
                check("n_phase", 32'(bus.L1A_PHASE_OUT), 32'(ne.ph));
                check("n_l1anum", 32'(bus.L1ANUM), 32'(ne.num));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        logic [5:0] n_vals [8];
        n_vals = '{6'd5, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11};

        bus.L1A = 0; bus.T_PUSH = 0; bus.T_CEW = 0; bus.T_POP = 0; bus.T_CER = 0;
        bus.LCT_PH_IN = 0; bus.DLSCAFULL = 0; bus.SCND_BLK_IN = 0; bus.SCND_SH_IN = 0;
        bus.BLKIN = 0; bus.L1PIN = 0; bus.N_PUSH = 0; bus.N_POP = 0; bus.L1A_PHASE = 0;
        repeat (2) tick();
        RST = 1'b0;
        tick();

        // Reset state
        check("rst_l1a_cnt", 32'(bus.L1A_CNT), 0);
        check("rst_dl1an", 32'(dut.dl1an), 0);
        check("rst_t_empty", 32'(bus.T_EMPTY), 1);
        check("rst_t_full", 32'(bus.T_FULL), 0);
        check("rst_n_empty", 32'(bus.N_EMPTY), 1);
        check("rst_n_full", 32'(bus.N_FULL), 0);
        check("rst_nl1ablk", 32'(bus.NL1ABLK), 'hFF);
        check("rst_blkout", 32'(bus.BLKOUT), 0);
        check("rst_l1anum", 32'(bus.L1ANUM), 0);
        check("rst_phase_out", 32'(bus.L1A_PHASE_OUT), 0);

        // 65 L1A pulses: wrap 63 -> 0 at the 64th, ending at 1
        bus.L1A = 1'b1;
        for (int i = 0; i < 65; i++) begin
            tick();
            check("t_empty_during_l1a", 32'(bus.T_EMPTY), 1);
            check("n_empty_during_l1a", 32'(bus.N_EMPTY), 1);
            if (i == 62) check("l1a_cnt_63", 32'(bus.L1A_CNT), 63);
            if (i == 63) check("l1a_cnt_wrap0", 32'(bus.L1A_CNT), 0);
        end
        bus.L1A = 1'b0;
        check("l1a_cnt_65", 32'(bus.L1A_CNT), 1);
        check("dl1an_lags", 32'(dut.dl1an), 0);
        tick();
        check("dl1an_follows", 32'(dut.dl1an), 1);

        // Trigger FIFO fill, drop on full, drain
        t_cycle(1, 1, 0, 0, 4'b1000, 4'd1, 8'h80, 8'h7F, 1);
        check("t_empty_after_push", 32'(bus.T_EMPTY), 0);
        check("t_head_same_cycle", 32'(bus.BLKOUT), 1);
        check("t_head_nl1ablk", 32'(bus.NL1ABLK), 'h7F);
        t_cycle(1, 1, 0, 0, 4'b0101, 4'd2, 8'h01, 8'hFE, 1);
        check("t_full_at_2", 32'(bus.T_FULL), 0);
        t_cycle(1, 1, 0, 0, 4'b0010, 4'd3, 8'h00, 8'hFF, 1);
        check("t_full_at_3", 32'(bus.T_FULL), 1);
        t_cycle(1, 1, 0, 0, 4'b1111, 4'd4, 8'hAA, 8'h55, 0);
        check("t_full_after_drop", 32'(bus.T_FULL), 1);
        check("t_head_after_drop", 32'(bus.BLKOUT), 1);
        t_cycle(0, 0, 1, 1, 4'b0000, 4'd0, 8'h00, 8'h00, 0);
        check("t_full_after_pop", 32'(bus.T_FULL), 0);
        t_cycle(0, 0, 1, 1, 4'b0000, 4'd0, 8'h00, 8'h00, 0);
        check("t_empty_before_last", 32'(bus.T_EMPTY), 0);
        t_cycle(0, 0, 1, 1, 4'b0000, 4'd0, 8'h00, 8'h00, 0);
        check("t_empty_after_3_pops", 32'(bus.T_EMPTY), 1);
        check("t_hold_blkout", 32'(bus.BLKOUT), 3);
        check("t_hold_scnd_blk", 32'(bus.SCND_BLK_OUT), 1);
        t_cycle(0, 0, 1, 1, 4'b0000, 4'd0, 8'h00, 8'h00, 0);
        check("t_pop_empty_ignored", 32'(bus.T_EMPTY), 1);
        check("t_pop_empty_hold", 32'(bus.BLKOUT), 3);

        // Unqualified push and pop
        t_cycle(1, 0, 0, 0, 4'b1111, 4'd7, 8'h00, 8'hFF, 0);
        check("t_push_no_cew", 32'(bus.T_EMPTY), 1);
        t_cycle(1, 1, 0, 0, 4'b0001, 4'd5, 8'h0F, 8'hF0, 1);
        check("t_push_with_cew", 32'(bus.T_EMPTY), 0);
        t_cycle(0, 0, 1, 0, 4'b0000, 4'd0, 8'h00, 8'h00, 0);
        check("t_pop_no_cer_empty", 32'(bus.T_EMPTY), 0);
        check("t_pop_no_cer_head", 32'(bus.BLKOUT), 5);

        // Full FIFO with simultaneous push and pop
        t_cycle(1, 1, 0, 0, 4'b0100, 4'd6, 8'h3C, 8'hC3, 1);
        t_cycle(1, 1, 0, 0, 4'b1001, 4'd7, 8'hFF, 8'h00, 1);
        check("t_full_before_swap", 32'(bus.T_FULL), 1);
        t_cycle(1, 1, 1, 1, 4'b0110, 4'd8, 8'h18, 8'hE7, 1);
        check("t_full_after_swap", 32'(bus.T_FULL), 1);
        check("t_head_after_swap", 32'(bus.BLKOUT), 6);
        repeat (3) t_cycle(0, 0, 1, 1, 4'b0000, 4'd0, 8'h00, 8'h00, 0);
        check("t_empty_after_swap_drain", 32'(bus.T_EMPTY), 1);
        check("t_hold_after_swap_drain", 32'(bus.BLKOUT), 8);

        // L1A-number FIFO
        bus.L1A = 1'b1;
        repeat (4) tick();
        bus.L1A = 1'b0;
        tick();
        check("l1a_cnt_5", 32'(bus.L1A_CNT), 5);
        n_cycle(1, 0, 0, 1, 6'd5, 1);
        check("n_empty_after_push", 32'(bus.N_EMPTY), 0);
        check("n_head_l1anum", 32'(bus.L1ANUM), 5);
        check("n_head_phase", 32'(bus.L1A_PHASE_OUT), 1);
        for (int k = 2; k <= 9; k++) begin
            n_cycle(1, 0, 1, k[0], n_vals[k-2], k <= 8);
            check("n_full_flag", 32'(bus.N_FULL), 32'(k >= 8));
        end
        check("l1a_cnt_13", 32'(bus.L1A_CNT), 13);
        repeat (8) n_cycle(0, 1, 0, 0, 6'd0, 0);
        check("n_empty_after_drain", 32'(bus.N_EMPTY), 1);
        check("n_hold_l1anum", 32'(bus.L1ANUM), 10);

        // Asynchronous reset with data in both FIFOs
        n_cycle(1, 0, 0, 0, 6'd13, 1);
        t_cycle(1, 1, 0, 0, 4'b1010, 4'd9, 8'h55, 8'hAA, 1);
        check("pre_rst_t_empty", 32'(bus.T_EMPTY), 0);
        check("pre_rst_n_empty", 32'(bus.N_EMPTY), 0);
        #2;
        RST = 1'b1;
        #1;
        check("arst_t_empty", 32'(bus.T_EMPTY), 1);
        check("arst_n_empty", 32'(bus.N_EMPTY), 1);
        check("arst_l1a_cnt", 32'(bus.L1A_CNT), 0);
        check("arst_nl1ablk", 32'(bus.NL1ABLK), 'hFF);
        check("arst_l1anum", 32'(bus.L1ANUM), 0);
        tq.delete();
        nq.delete();
        tick();
        RST = 1'b0;
        t_cycle(1, 1, 0, 0, 4'b0011, 4'd12, 8'hF0, 8'h0F, 1);
        check("post_rst_t_empty", 32'(bus.T_EMPTY), 0);
        check("post_rst_t_head", 32'(bus.BLKOUT), 12);
        n_cycle(1, 0, 0, 1, 6'd0, 1);
        check("post_rst_n_empty", 32'(bus.N_EMPTY), 0);
        check("post_rst_n_head", 32'(bus.L1ANUM), 0);
        check("post_rst_n_phase", 32'(bus.L1A_PHASE_OUT), 1);
        t_cycle(0, 0, 1, 1, 4'b0000, 4'd0, 8'h00, 8'h00, 0);
        n_cycle(0, 1, 0, 0, 6'd0, 0);
        check("final_t_empty", 32'(bus.T_EMPTY), 1);
        check("final_n_empty", 32'(bus.N_EMPTY), 1);
        check("t_scoreboard_drained", 32'(tq.size()), 0);
        check("n_scoreboard_drained", 32'(nq.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
